prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 40 ++++
 rtl/prog_loader_if.sv | 20 ++
 rtl/prog_loader_byte_packer.sv | 52 +++++
 rtl/prog_loader.sv | 218 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// length width, default program size and small decode/checksum helpers.
package prog_loader_pkg;

  localparam int LEN_W             = 16;
  localparam int MAX_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  // Running checksum is a plain XOR of the payload bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

  // States in which the loader offers byte_ready.
  function automatic logic takes_bytes(input state_t s);
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // States that make up an active session (length bytes through checksum).
  function automatic logic is_busy(input state_t s);
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a byte source (master) and the loader (slave).
interface prog_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler: tracks which byte lane comes next,
// exposes the word as it would look with the current byte merged in, and
// pulses word_valid for one cycle after the fourth byte of a word.
module byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic [31:0] word_next,
  output logic        word_valid
);

  logic [1:0]  idx_r;
  logic [31:0] word_r;
  logic        valid_r;

  // Merge the offered byte into the lane selected by the current index.
  always_comb begin
    word_next = word_r;
    case (idx_r)
      2'd0:    word_next[7:0]   = byte_in;
      2'd1:    word_next[15:8]  = byte_in;
      2'd2:    word_next[23:16] = byte_in;
      default: word_next[31:24] = byte_in;
    endcase
  end

  // Lane index, word assembly and completion pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_r   <= 2'd0;
      word_r  <= 32'd0;
      valid_r <= 1'b0;
    end else if (clear) begin
      idx_r   <= 2'd0;
      word_r  <= 32'd0;
      valid_r <= 1'b0;
    end else if (byte_en) begin
      idx_r   <= idx_r + 2'd1;
      word_r  <= word_next;
      valid_r <= (idx_r == 2'd3);
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign last       = (idx_r == 2'd3);
  assign word_valid = valid_r;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed byte
// stream, writes it word by word into instruction memory and holds the CPU
// in reset until a session completes with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  prog_loader_if.slave     bs,
  output logic             prog_load_en,
  output logic [31:0]      prog_addr,
  output logic [31:0]      prog_data,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

  state_t           state_r;
  state_t           state_n;

  logic [7:0]       len_lo_r;
  logic [LEN_W-1:0] len_r;
  logic [7:0]       csum_r;
  logic [LEN_W-1:0] words_r;

  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             cpu_reset_r;
  logic             prog_load_en_r;
  logic [31:0]      prog_addr_r;
  logic [31:0]      prog_data_r;

  logic             accept_s;
  logic             take_start_s;
  logic             pack_en_s;
  logic             pack_clear_s;
  logic             write_s;
  logic             last_s;
  logic             word_valid_s;
  logic [31:0]      word_next_s;
  logic [LEN_W-1:0] len_full_s;
  logic             len_bad_s;
  logic             count_hit_s;

  assign len_full_s   = {bs.byte_data, len_lo_r};
  assign len_bad_s    = (len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_LEN);
  assign count_hit_s  = ((words_r + 16'd1) == len_r);
  // A starting session or an abort throws away any partially packed word.
  assign pack_clear_s = abort | take_start_s;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear_s),
    .byte_en    (pack_en_s),
    .byte_in    (bs.byte_data),
    .last       (last_s),
    .word_next  (word_next_s),
    .word_valid (word_valid_s)
  );

  // Next-state decode; abort overrides start and any byte on offer.
  always_comb begin
    state_n      = state_r;
    accept_s     = bs.byte_valid & ready_r & ~abort;
    take_start_s = 1'b0;
    pack_en_s    = 1'b0;
    write_s      = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_n      = ST_LEN_LO;
            take_start_s = 1'b1;
          end else begin
            state_n = state_r;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            state_n = ST_LEN_HI;
          end else begin
            state_n = state_r;
          end
        end
        ST_LEN_HI: begin
          if (accept_s) begin
            if (len_bad_s) begin
              state_n = ST_ERR;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            pack_en_s = 1'b1;
            if (last_s) begin
              state_n = ST_WRITE;
              write_s = 1'b1;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_WRITE: begin
          if (count_hit_s) begin
            state_n = ST_CSUM;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            if (bs.byte_data == csum_r) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_ERR;
            end
          end else begin
            state_n = state_r;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Session bookkeeping: length capture, checksum and written-word count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_lo_r <= 8'd0;
      len_r    <= 16'd0;
      csum_r   <= 8'd0;
      words_r  <= 16'd0;
    end else if (take_start_s) begin
      words_r  <= 16'd0;
      csum_r   <= 8'd0;
    end else if (word_valid_s) begin
      words_r  <= words_r + 16'd1;
    end else if (accept_s) begin
      case (state_r)
        ST_LEN_LO: len_lo_r <= bs.byte_data;
        ST_LEN_HI: len_r    <= len_full_s;
        ST_DATA:   csum_r   <= csum_next(csum_r, bs.byte_data);
        default:   csum_r   <= csum_r;
      endcase
    end else begin
      csum_r <= csum_r;
    end
  end

  // Registered outputs, derived from the state being entered so they line
  // up with it; the write bus is loaded on entry to WRITE and then held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      cpu_reset_r    <= 1'b1;
      prog_load_en_r <= 1'b0;
      prog_addr_r    <= 32'd0;
      prog_data_r    <= 32'd0;
    end else begin
      ready_r        <= takes_bytes(state_n);
      busy_r         <= is_busy(state_n);
      done_r         <= (state_n == ST_DONE);
      error_r        <= (state_n == ST_ERR);
      cpu_reset_r    <= (state_n != ST_DONE);
      prog_load_en_r <= write_s;
      if (write_s) begin
        prog_addr_r <= BASE_ADDR + {14'd0, words_r, 2'b00};
        prog_data_r <= word_next_s;
      end else begin
        prog_addr_r <= prog_addr_r;
        prog_data_r <= prog_data_r;
      end
    end
  end

  assign bs.byte_ready = ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign cpu_reset     = cpu_reset_r;
  assign prog_load_en  = prog_load_en_r;
  assign prog_addr     = prog_addr_r;
  assign prog_data     = prog_data_r;
  assign words_loaded  = words_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed sessions plus randomized
// loads, checked against a word/checksum model built from the byte list.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        prog_load_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  prog_loader_if bs();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bs(bs),
    .prog_load_en(prog_load_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  byte_q[$];

  // Record every write strobe seen on the memory bus.
  always @(negedge clk) begin
    if (prog_load_en === 1'b1) begin
      wr_addr_q.push_back(prog_addr);
      wr_data_q.push_back(prog_data);
    end
  end

  // Overall time limit.
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---- reference model: words are the byte list taken four at a time ----
  function automatic void model_load(input int nwords);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int w = 0; w < nwords; w++) begin
      exp_addr_q.push_back(BASE + 32'(4 * w));
      exp_data_q.push_back({byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]});
    end
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] x;
    x = 8'h00;
    foreach (byte_q[i]) x = x ^ byte_q[i];
    return x;
  endfunction

  task automatic fill_random(input int nwords);
    byte_q.delete();
    repeat (4 * nwords) byte_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---- stimulus drivers ----
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    while (bs.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bs.byte_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL byte_ready_wait got=%b want=1", bs.byte_ready);
    end
    @(negedge clk);
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
  endtask

  task automatic run_load(input logic [15:0] len, input logic [7:0] cs, input int gap);
    start_pulse();
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (len != 16'd0 && int'(len) <= MAXW) begin
      foreach (byte_q[i]) send_byte(byte_q[i], gap);
      send_byte(cs, gap);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    bs.byte_valid = 1'b0; bs.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b want=1", cpu_reset); end
    total++;
    if ({busy, done, error, prog_load_en, bs.byte_ready} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, error, prog_load_en, bs.byte_ready});
    end
    total++;
    if (prog_addr !== 32'd0 || prog_data !== 32'd0 || words_loaded !== 16'd0) begin
      bad++; $display("FAIL reset_bus got=%h/%h/%0d want=0/0/0", prog_addr, prog_data, words_loaded);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b%b want=10", cpu_reset, busy);
    end
  endtask

  // The checksum byte is the XOR of the eight data bytes, 0xB0.
  task automatic test_known_stream(input logic [7:0] cs, input logic good);
    byte_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    wr_addr_q.delete(); wr_data_q.delete();
    run_load(16'd2, cs, 0);
    #1;
    total++;
    if (wr_addr_q.size() != 2) begin
      bad++; $display("FAIL known_write_count got=%0d want=2", wr_addr_q.size());
    end else begin
      total++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h0010_0513) begin
        bad++; $display("FAIL known_write0 got=%h:%h want=0:00100513", wr_addr_q[0], wr_data_q[0]);
      end
      total++;
      if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h0020_0593) begin
        bad++; $display("FAIL known_write1 got=%h:%h want=4:00200593", wr_addr_q[1], wr_data_q[1]);
      end
    end
    total++;
    if (done !== good || error !== !good || cpu_reset !== !good || busy !== 1'b0) begin
      bad++; $display("FAIL known_status got=d%b e%b c%b b%b want=d%b e%b c%b b0",
                      done, error, cpu_reset, busy, good, !good, !good);
    end
    total++;
    if (words_loaded !== 16'd2) begin bad++; $display("FAIL known_words got=%0d want=2", words_loaded); end
  endtask

  task automatic test_bad_length(input logic [15:0] len);
    wr_addr_q.delete(); wr_data_q.delete();
    start_pulse();
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    #1;
    total++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b0 || bs.byte_ready !== 1'b0) begin
      bad++; $display("FAIL bad_len_%0d_status got=e%b d%b c%b b%b r%b want=e1 d0 c1 b0 r0",
                      len, error, done, cpu_reset, busy, bs.byte_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (wr_addr_q.size() != 0) begin bad++; $display("FAIL bad_len_%0d_writes got=%0d want=0", len, wr_addr_q.size()); end
  endtask

  task automatic test_stalls();
    fill_random(1);
    model_load(1);
    wr_addr_q.delete(); wr_data_q.delete();
    run_load(16'd1, model_csum(), 5);
    #1;
    total++;
    if (wr_addr_q.size() != 1) begin
      bad++; $display("FAIL stall_write_count got=%0d want=1", wr_addr_q.size());
    end else begin
      total++;
      if (wr_addr_q[0] !== exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0]) begin
        bad++; $display("FAIL stall_write got=%h:%h want=%h:%h", wr_addr_q[0], wr_data_q[0], exp_addr_q[0], exp_data_q[0]);
      end
    end
    total++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || words_loaded !== 16'd1) begin
      bad++; $display("FAIL stall_status got=d%b c%b w%0d want=d1 c0 w1", done, cpu_reset, words_loaded);
    end
  endtask

  task automatic test_max_len();
    int errs;
    errs = 0;
    fill_random(MAXW);
    model_load(MAXW);
    wr_addr_q.delete(); wr_data_q.delete();
    run_load(16'(MAXW), model_csum(), 0);
    #1;
    total++;
    if (wr_addr_q.size() != MAXW) begin
      bad++; $display("FAIL max_write_count got=%0d want=%0d", wr_addr_q.size(), MAXW);
    end else begin
      foreach (exp_addr_q[i])
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("FAIL max_write_data got=%0d_bad_words want=0", errs); end
      total++;
      if (wr_addr_q[MAXW-1] !== 32'h0000_0FFC) begin
        bad++; $display("FAIL max_last_addr got=%h want=00000ffc", wr_addr_q[MAXW-1]);
      end
    end
    total++;
    if (done !== 1'b1 || words_loaded !== 16'(MAXW)) begin
      bad++; $display("FAIL max_status got=d%b w%0d want=d1 w%0d", done, words_loaded, MAXW);
    end
  endtask

  task automatic test_abort();
    fill_random(2);
    wr_addr_q.delete(); wr_data_q.delete();
    start_pulse();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(byte_q[0], 0);
    send_byte(byte_q[1], 0);
    abort = 1'b1; start = 1'b1;
    bs.byte_valid = 1'b1; bs.byte_data = byte_q[2];
    @(negedge clk);
    abort = 1'b0; start = 1'b0; bs.byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1 || bs.byte_ready !== 1'b0) begin
      bad++; $display("FAIL abort_status got=b%b d%b e%b c%b r%b want=b0 d0 e0 c1 r0",
                      busy, done, error, cpu_reset, bs.byte_ready);
    end
    total++;
    if (wr_addr_q.size() != 0 || words_loaded !== 16'd0) begin
      bad++; $display("FAIL abort_writes got=%0d/%0d want=0/0", wr_addr_q.size(), words_loaded);
    end
    fill_random(3);
    model_load(3);
    run_load(16'd3, model_csum(), 1);
    #1;
    total++;
    if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q) begin
      bad++; $display("FAIL abort_reload_writes got=%0d_writes want=%0d", wr_addr_q.size(), exp_addr_q.size());
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL abort_reload_done got=%b want=1", done); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++; $display("FAIL abort_from_done got=d%b c%b want=d0 c1", done, cpu_reset);
    end
  endtask

  task automatic test_reset_mid();
    fill_random(1);
    wr_addr_q.delete(); wr_data_q.delete();
    start_pulse();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) send_byte(byte_q[i], 0);
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (prog_addr !== 32'd0 || prog_data !== 32'd0 || words_loaded !== 16'd0 || cpu_reset !== 1'b1 ||
        busy !== 1'b0 || bs.byte_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs got=%h/%h/%0d c%b b%b want=0/0/0 c1 b0",
                      prog_addr, prog_data, words_loaded, cpu_reset, busy);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (wr_addr_q.size() != 0) begin bad++; $display("FAIL midreset_writes got=%0d want=0", wr_addr_q.size()); end
    fill_random(3);
    model_load(3);
    run_load(16'd3, model_csum(), 0);
    #1;
    total++;
    if (wr_addr_q.size() != 3) begin
      bad++; $display("FAIL midreset_reload_count got=%0d want=3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== exp_data_q[i]) begin
          bad++; $display("FAIL midreset_reload_w%0d got=%h:%h want=%h:%h", i, wr_addr_q[i], wr_data_q[i], 4 * i, exp_data_q[i]);
        end
      end
    end
  endtask

  task automatic test_restart_from_done();
    fill_random(2);
    model_load(2);
    wr_addr_q.delete(); wr_data_q.delete();
    start_pulse();
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || words_loaded !== 16'd0 || bs.byte_ready !== 1'b1) begin
      bad++; $display("FAIL restart_first_cycle got=c%b d%b b%b w%0d r%b want=c1 d0 b1 w0 r1",
                      cpu_reset, done, busy, words_loaded, bs.byte_ready);
    end
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_byte(byte_q[i], 0);
    start_pulse();
    for (int i = 4; i < 8; i++) send_byte(byte_q[i], 0);
    send_byte(model_csum(), 0);
    #1;
    total++;
    if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q) begin
      bad++; $display("FAIL restart_writes got=%0d_writes want=%0d", wr_addr_q.size(), exp_addr_q.size());
    end
    total++;
    if (done !== 1'b1 || words_loaded !== 16'd2) begin
      bad++; $display("FAIL restart_status got=d%b w%0d want=d1 w2", done, words_loaded);
    end
  endtask

  task automatic test_random();
    int          n;
    int          gap;
    logic        corrupt;
    logic        badlen;
    logic [15:0] len;
    logic [7:0]  cs;
    for (int it = 0; it < 20; it++) begin
      n       = $urandom_range(1, 6);
      gap     = $urandom_range(0, 2);
      corrupt = ($urandom_range(0, 3) == 0);
      badlen  = ($urandom_range(0, 5) == 0);
      fill_random(n);
      cs = model_csum() ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'h00);
      if (badlen) begin
        len = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAXW + 1, 65535));
        model_load(0);
      end else begin
        len = 16'(n);
        model_load(n);
      end
      wr_addr_q.delete(); wr_data_q.delete();
      run_load(len, cs, gap);
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (wr_addr_q != exp_addr_q || wr_data_q != exp_data_q) begin
        bad++; $display("FAIL rand%0d_writes got=%0d_writes want=%0d len=%0d", it, wr_addr_q.size(), exp_addr_q.size(), len);
      end
      total++;
      if (done !== !(corrupt | badlen) || error !== (corrupt | badlen) || cpu_reset !== (corrupt | badlen)) begin
        bad++; $display("FAIL rand%0d_status got=d%b e%b c%b want=d%b e%b c%b", it, done, error, cpu_reset,
                        !(corrupt | badlen), corrupt | badlen, corrupt | badlen);
      end
      total++;
      if (words_loaded !== 16'(exp_addr_q.size())) begin
        bad++; $display("FAIL rand%0d_words got=%0d want=%0d", it, words_loaded, exp_addr_q.size());
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_known_stream(8'hB0, 1'b1);
    test_known_stream(8'h00, 1'b0);
    test_bad_length(16'h0000);
    test_bad_length(16'h0401);
    test_stalls();
    test_abort();
    test_reset_mid();
    test_restart_from_done();
    test_max_len();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
